// File: rtl/pmod8led2_pkg.sv
// Shared definitions for the PMOD 8LED2 pattern engine: mode encodings, scan direction,
// and the binary-to-Gray helper.
package pmod8led2_pkg;

    localparam logic [1:0] MODE_UP   = 2'd0;
    localparam logic [1:0] MODE_DOWN = 2'd1;
    localparam logic [1:0] MODE_GRAY = 2'd2;
    localparam logic [1:0] MODE_SCAN = 2'd3;

    typedef enum logic {DirUp, DirDown} dir_e;

    // Fixed 32-bit width; callers cast to and from their own pattern width.
    function automatic logic [31:0] gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/pmod8led2_pattern_tick_gen.sv
// Free-running prescaler: tick_o is a one-cycle pulse per CLK_HZ/TICK_HZ clocks.
// The pulse decodes the terminal count so a consumer can act on the wrap edge itself.
module tick_gen #(
    parameter int unsigned CLK_HZ  = 25_000_000,
    parameter int unsigned TICK_HZ = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int unsigned Div  = CLK_HZ / TICK_HZ;
    localparam int unsigned CntW = $clog2(Div);
    localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == CntMax);

endmodule

// File: rtl/pmod8led2_pattern.sv
// LED pattern engine for the bicolor PMOD 8LED2: heartbeat on LED0 red, selectable
// up/down/Gray/scanner pattern on LEDs 1..NLED-1, one-period red flash on counter wrap.
module pmod8led2_pattern
    import pmod8led2_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 25_000_000,
    parameter int unsigned TICK_HZ = 2,
    parameter int unsigned NLED    = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic [1:0]      mode_i,
    output logic            tick_o,
    output logic [0:NLED-1] pmodledg_o,
    output logic [0:NLED-1] pmodledr_o
);

    localparam int unsigned W    = NLED - 1;
    localparam int unsigned PosW = $clog2(W);
    localparam logic [PosW-1:0] PosMax   = PosW'(W - 1);
    localparam logic [PosW-1:0] PosMaxM1 = PosW'(W - 2);
    localparam logic [W-1:0]    ScanTop  = {1'b1, {(W-1){1'b0}}};

    logic            step;
    logic [1:0]      mode_q, mode_d;
    logic [W-1:0]    val_q, val_d;
    logic [PosW-1:0] pos_q, pos_d;
    dir_e            dir_q, dir_d;
    logic            hb_q, hb_d;
    logic            wflag_q, wflag_d;
    logic            tick_q;
    logic [W-1:0]    pat;
    // Bit NLED-1 drives port index 0 (LED0); the pattern MSB lands on LED1.
    logic [NLED-1:0] ledg_q, ledg_d, ledr_q, ledr_d;

    tick_gen #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .tick_o (step)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q  <= MODE_UP;
            val_q   <= '0;
            pos_q   <= '0;
            dir_q   <= DirUp;
            hb_q    <= 1'b0;
            wflag_q <= 1'b0;
            tick_q  <= 1'b0;
            ledg_q  <= '0;
            ledr_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            val_q   <= val_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            hb_q    <= hb_d;
            wflag_q <= wflag_d;
            tick_q  <= step;
            ledg_q  <= ledg_d;
            ledr_q  <= ledr_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        val_d   = val_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        hb_d    = hb_q;
        wflag_d = wflag_q;
        if (step) begin
            hb_d    = ~hb_q;
            wflag_d = 1'b0;
            mode_d  = mode_i;
            if (mode_i != mode_q) begin
                // A mode switch restarts the pattern rather than stepping it.
                val_d = '0;
                pos_d = '0;
                dir_d = DirUp;
            end else if (en_i) begin
                unique case (mode_q)
                    MODE_UP, MODE_GRAY: begin
                        val_d   = val_q + W'(1);
                        wflag_d = (val_q == '1);
                    end
                    MODE_DOWN: begin
                        val_d   = val_q - W'(1);
                        wflag_d = (val_q == '0);
                    end
                    MODE_SCAN: begin
                        if (dir_q == DirUp) begin
                            if (pos_q == PosMax) begin
                                pos_d = PosMaxM1;
                                dir_d = DirDown;
                            end else begin
                                pos_d = pos_q + PosW'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                pos_d = PosW'(1);
                                dir_d = DirUp;
                            end else begin
                                pos_d = pos_q - PosW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        pat = '0;
        unique case (mode_q)
            MODE_UP, MODE_DOWN: pat = val_q;
            MODE_GRAY:          pat = W'(gray(32'(val_q)));
            MODE_SCAN:          pat = ScanTop >> pos_q;
            default:            pat = '0;
        endcase
        ledg_d = {1'b0, (wflag_q ? {W{1'b0}} : pat)};
        ledr_d = {hb_q, (wflag_q ? {W{1'b1}} : {W{1'b0}})};
    end

    assign tick_o     = tick_q;
    assign pmodledg_o = ledg_q;
    assign pmodledr_o = ledr_q;

endmodule

// File: tb/tb_pmod8led2_pattern.sv
// Directed bench for pmod8led2_pattern with DIV=4 and W=3; edge t counts posedges
// after reset release, outputs sampled 1 time unit after each edge.
module tb_pmod8led2_pattern;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       tick;
    logic [0:3] g, r;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    pmod8led2_pattern #(
        .CLK_HZ  (8),
        .TICK_HZ (2),
        .NLED    (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .en_i       (en),
        .mode_i     (mode),
        .tick_o     (tick),
        .pmodledg_o (g),
        .pmodledr_o (r)
    );

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            cyc = cyc + 1;
        end
        #1;
    endtask

    task automatic start(input logic [1:0] m, input logic e);
        rst_n = 1'b0;
        mode  = m;
        en    = e;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", tick); end
        checks++;
        if (g !== 4'b0000) begin errors++; $display("FAIL reset_green got %b want 0000", g); end
        checks++;
        if (r !== 4'b0000) begin errors++; $display("FAIL reset_red got %b want 0000", r); end
    endtask

    task automatic test_up_count();
        logic [2:0] exp_g [3];
        logic       exp_hb [3];
        exp_g  = '{3'b001, 3'b010, 3'b011};
        exp_hb = '{1'b1, 1'b0, 1'b1};
        start(2'd0, 1'b1);
        for (int t = 1; t <= 13; t++) begin
            go(t);
            checks++;
            if (tick !== ((t % 4) == 0)) begin
                errors++;
                $display("FAIL up_tick t=%0d got %b want %b", t, tick, ((t % 4) == 0));
            end
            if (t % 4 == 1 && t > 1) begin
                checks++;
                if (g[1:3] !== exp_g[t/4-1]) begin
                    errors++;
                    $display("FAIL up_green t=%0d got %b want %b", t, g[1:3], exp_g[t/4-1]);
                end
                checks++;
                if (r[0] !== exp_hb[t/4-1]) begin
                    errors++;
                    $display("FAIL up_hb t=%0d got %b want %b", t, r[0], exp_hb[t/4-1]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        start(2'd0, 1'b1);
        go(29);
        checks++;
        if (g[1:3] !== 3'b111) begin errors++; $display("FAIL wrap_pre got %b want 111", g[1:3]); end
        for (int t = 33; t <= 36; t++) begin
            go(t);
            checks++;
            if (r[1:3] !== 3'b111 || g[1:3] !== 3'b000) begin
                errors++;
                $display("FAIL wrap_flash t=%0d got r=%b g=%b want r=111 g=000", t, r[1:3], g[1:3]);
            end
        end
        go(37);
        checks++;
        if (r[1:3] !== 3'b000 || g[1:3] !== 3'b001) begin
            errors++;
            $display("FAIL wrap_after got r=%b g=%b want r=000 g=001", r[1:3], g[1:3]);
        end
    endtask

    task automatic test_down_restart();
        start(2'd1, 1'b1);
        go(5);
        checks++;
        if (g[1:3] !== 3'b000 || r[1:3] !== 3'b000) begin
            errors++;
            $display("FAIL down_restart got g=%b r=%b want 000 000", g[1:3], r[1:3]);
        end
        go(9);
        checks++;
        if (r[1:3] !== 3'b111 || g[1:3] !== 3'b000) begin
            errors++;
            $display("FAIL down_wrap got r=%b g=%b want r=111 g=000", r[1:3], g[1:3]);
        end
        go(13);
        checks++;
        if (g[1:3] !== 3'b110 || r[1:3] !== 3'b000) begin
            errors++;
            $display("FAIL down_step got g=%b r=%b want g=110 r=000", g[1:3], r[1:3]);
        end
    endtask

    task automatic test_gray();
        logic [2:0] exp_g [5];
        exp_g = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
        start(2'd2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            go(5 + 4 * k);
            checks++;
            if (g[1:3] !== exp_g[k]) begin
                errors++;
                $display("FAIL gray k=%0d got %b want %b", k, g[1:3], exp_g[k]);
            end
        end
    endtask

    task automatic test_scan();
        logic [2:0] exp_g [6];
        exp_g = '{3'b100, 3'b010, 3'b001, 3'b010, 3'b100, 3'b010};
        start(2'd3, 1'b1);
        for (int k = 0; k < 6; k++) begin
            go(5 + 4 * k);
            checks++;
            if (g[1:3] !== exp_g[k] || r[1:3] !== 3'b000) begin
                errors++;
                $display("FAIL scan k=%0d got g=%b r=%b want g=%b r=000", k, g[1:3], r[1:3],
                         exp_g[k]);
            end
        end
    endtask

    task automatic test_freeze_and_reset();
        logic exp_hb [3];
        exp_hb = '{1'b1, 1'b0, 1'b1};
        start(2'd0, 1'b1);
        go(9);
        checks++;
        if (g[1:3] !== 3'b010 || r[0] !== 1'b0) begin
            errors++;
            $display("FAIL freeze_pre got g=%b hb=%b want g=010 hb=0", g[1:3], r[0]);
        end
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            go(13 + 4 * k);
            checks++;
            if (g[1:3] !== 3'b010 || r[0] !== exp_hb[k]) begin
                errors++;
                $display("FAIL freeze k=%0d got g=%b hb=%b want g=010 hb=%b", k, g[1:3], r[0],
                         exp_hb[k]);
            end
        end
        // Mode change while disabled still restarts the pattern.
        mode = 2'd1;
        go(25);
        checks++;
        if (g[1:3] !== 3'b000 || r[0] !== 1'b0) begin
            errors++;
            $display("FAIL freeze_restart got g=%b hb=%b want g=000 hb=0", g[1:3], r[0]);
        end
        mode = 2'd0;
        en   = 1'b1;
        go(30);
        checks++;
        if (g[1:3] !== 3'b000 || r[0] !== 1'b1) begin
            errors++;
            $display("FAIL prereset got g=%b hb=%b want g=000 hb=1", g[1:3], r[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (g !== 4'b0000 || r !== 4'b0000 || tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset got g=%b r=%b tick=%b want 0000 0000 0", g, r, tick);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_wrap();
        test_down_restart();
        test_gray();
        test_scan();
        test_freeze_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
